blk_ctrl_responder: RTL and testbench
=====================================

Name: blk_ctrl_responder

Overview:
- Block-side end of the core control protocol: accepts CMD_BLK_G-style commands from the core control flow and returns ST_BLK_G-style status.
- Wraps a DEPTH-entry pipeline buffer with valid/ready on both sides, so each pipeline block (page walker, instr loader, decoder, RSV, ROB…) gets uniform start/stall/flush/stop behaviour.
- One instance sits between each block's datapath and the core control flow.

Parameters:
- DATA_W, 64, width of the payload carried through the stage buffer.
- DEPTH, 2, buffer entries; power of two, minimum 2.
- FLUSH_CYC, 2, cycles spent in FLUSH before returning to RUN; minimum 1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present this cycle.
- cmd_op  in  3  0 NOP, 1 START, 2 STALL, 3 RESUME, 4 FLUSH, 5 STOP; 6–7 illegal.
- st_state  out  3  0 IDLE, 1 RUN, 2 STALL, 3 FLUSH, 4 DRAIN.
- st_busy  out  1  count!=0 or state==FLUSH.
- st_ack  out  1  one-cycle pulse, cycle after a legal command is taken.
- st_err  out  1  one-cycle pulse, cycle after an illegal command or op.
- st_count  out  $clog2(DEPTH+1)  buffer occupancy.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  stage accepts data.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage offers data.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head-of-buffer payload.

Behaviour:
- Reset (synchronous, active-high; clk, rst): state IDLE, count 0, pointers 0. st_ack, st_err, in_ready and out_valid are 0. Reset mid-operation discards buffered data in that same edge.
- in_ready = (state==RUN) && (count<DEPTH). It is derived from registered state only, never from cmd_*.
- out_valid = (state==RUN || state==DRAIN) && count>0. out_data = mem[rd_ptr].
- In IDLE, STALL and FLUSH, both in_ready and out_valid are 0.
- Push when in_valid&&in_ready; pop when out_valid&&out_ready. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- NOP or cmd_valid=0: no state change, no ack.
- Legal transitions take effect at the edge; st_ack asserts the next cycle:
  - IDLE: START → RUN.
  - RUN: STALL → STALL; FLUSH → FLUSH; STOP → DRAIN.
  - STALL: RESUME → RUN; FLUSH → FLUSH; STOP → DRAIN.
  - DRAIN: FLUSH → FLUSH.
  - FLUSH: accepts no commands.
- FLUSH entry:
  - count, rd_ptr and wr_ptr are cleared at the same edge.
  - A push handshake in that cycle is discarded.
  - A pop handshake in that cycle completes downstream; the data is not recalled.
  - A down-counter loads FLUSH_CYC-1. When it reaches 0, state → RUN with no ack.
- DRAIN: no pushes. When count reaches 0 (including via a pop in that cycle), state → IDLE at that edge.
- Any other command is illegal: st_err pulses, state is unchanged, no ack. This includes opcodes 6–7, START in RUN, RESUME in RUN, and any command in FLUSH.
- st_ack and st_err are mutually exclusive and registered.
- Buffer contents are retained across STALL.

Decomposition:
- Shared package blk_ctrl_pkg:
  - enum blk_cmd_e (3-bit opcodes);
  - enum blk_state_e (3-bit states);
  - struct blk_cmd_t {valid, op};
  - struct blk_st_t {state, busy, ack, err, count}.
  These map onto the CMD_BLK_G/ST_BLK_G bundles.
- Sub-module blk_ctrl_fifo holds storage, pointers and count, with push, pop and clear inputs. The FSM and command decode stay in blk_ctrl_responder.

Test Plan:
- Reset, then START at cycle 2 → st_ack=1 at cycle 3, st_state=1, in_ready=1. Push 0xA, 0xB with out_ready=0 → st_count=2, in_ready=0. Raise out_ready → 0xA then 0xB out in order.
- RUN with 2 entries, STALL → out_valid=0, in_ready=0, count held at 2. RESUME → 0xA emitted first.
- FLUSH with count=2 and push in the same cycle (FLUSH_CYC=2) → st_state=3 for 2 cycles, count=0, st_busy=1. Then state=1 with no ack, and the pushed word never appears.
- STOP with count=1 and out_ready held 0 for 3 cycles → state=4, in_ready=0. Release out_ready → pop, then state=0 next cycle.
- Illegal commands: RESUME in IDLE, op=7, START in RUN → st_err pulses once each, no ack, state unchanged.
- Assert rst during DRAIN with count=2 → next cycle state=0, count=0, out_valid=0. START is then accepted normally.

Source files
------------

// File: rtl/blk_ctrl_pkg.sv
// Shared command/status encodings for the block-side control protocol.
// Also holds the command transition table used by every responder instance.
package blk_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_START  = 3'd1,
        CMD_STALL  = 3'd2,
        CMD_RESUME = 3'd3,
        CMD_FLUSH  = 3'd4,
        CMD_STOP   = 3'd5
    } blk_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4
    } blk_state_e;

    localparam int BLK_CNT_W = 8;

    typedef struct packed {
        logic     valid;
        blk_cmd_e op;
    } blk_cmd_t;

    typedef struct packed {
        blk_state_e           state;
        logic                 busy;
        logic                 ack;
        logic                 err;
        logic [BLK_CNT_W-1:0] count;
    } blk_st_t;

    // Every legal command changes state, so "target == current" marks an illegal one.
    function automatic blk_state_e cmd_target(input blk_state_e s, input blk_cmd_e op);
        cmd_target = s;
        case (s)
            ST_IDLE:  if (op == CMD_START) cmd_target = ST_RUN;
            ST_RUN: begin
                if (op == CMD_STALL) cmd_target = ST_STALL;
                if (op == CMD_FLUSH) cmd_target = ST_FLUSH;
                if (op == CMD_STOP)  cmd_target = ST_DRAIN;
            end
            ST_STALL: begin
                if (op == CMD_RESUME) cmd_target = ST_RUN;
                if (op == CMD_FLUSH)  cmd_target = ST_FLUSH;
                if (op == CMD_STOP)   cmd_target = ST_DRAIN;
            end
            ST_DRAIN: if (op == CMD_FLUSH) cmd_target = ST_FLUSH;
            default:  cmd_target = s;
        endcase
    endfunction

endpackage

// File: rtl/blk_ctrl_fifo.sv
// Stage buffer: DEPTH-entry circular store with push/pop and a clear that
// wins over a same-cycle push.
module blk_ctrl_fifo #(
    parameter int  DATA_W = 64,
    parameter int  DEPTH  = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign rdata = mem[rd_ptr];

    // NOTE: payload storage carries no reset; occupancy and pointers alone say what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/blk_ctrl_responder.sv
// Block-side control responder: decodes core commands into the stage FSM,
// reports status, and gates the stage buffer's valid/ready handshakes.
module blk_ctrl_responder
    import blk_ctrl_pkg::*;
#(
    parameter int  DATA_W    = 64,
    parameter int  DEPTH     = 2,
    parameter int  FLUSH_CYC = 2,
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int FW        = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    output logic [2:0]        st_state,
    output logic              st_busy,
    output logic              st_ack,
    output logic              st_err,
    output logic [CW-1:0]     st_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);

    blk_state_e    state;
    logic [FW-1:0] flush_cnt;
    logic [CW-1:0] count;
    blk_cmd_t      cmd;
    blk_state_e    cmd_next;
    logic          cmd_active, cmd_legal, cmd_illegal;
    logic          push, pop, flush_entry, drain_done;

    assign cmd         = '{valid: cmd_valid, op: blk_cmd_e'(cmd_op)};
    assign cmd_active  = cmd.valid && (cmd.op != CMD_NOP);
    assign cmd_next    = cmd_target(state, cmd.op);
    assign cmd_legal   = cmd_active && (cmd_next != state);
    assign cmd_illegal = cmd_active && !cmd_legal;
    assign flush_entry = cmd_legal && (cmd_next == ST_FLUSH);

    // Handshake qualifiers come from registered state and occupancy only.
    assign in_ready  = (state == ST_RUN) && (count < DEPTH_C);
    assign out_valid = ((state == ST_RUN) || (state == ST_DRAIN)) && (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign drain_done = (count == '0) || ((count == CW'(1)) && pop);

    assign st_state = state;
    assign st_count = count;
    assign st_busy  = (count != '0) || (state == ST_FLUSH);

    blk_ctrl_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush_entry),
        .wdata (in_data),
        .rdata (out_data),
        .count (count)
    );

    // A legal command is assigned last so it overrides the autonomous FLUSH/DRAIN exits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            st_ack    <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            st_ack <= cmd_legal;
            st_err <= cmd_illegal;
            case (state)
                ST_FLUSH: begin
                    if (flush_cnt == '0) state <= ST_RUN;
                    else                 flush_cnt <= flush_cnt - 1'b1;
                end
                ST_DRAIN: if (drain_done) state <= ST_IDLE;
                default:  ;
            endcase
            if (cmd_legal) begin
                state <= cmd_next;
                if (cmd_next == ST_FLUSH) flush_cnt <= FLUSH_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_blk_ctrl_responder.sv
// Directed bench for blk_ctrl_responder: command sequencing, buffer ordering,
// stall retention, flush discard, drain exit, illegal commands and reset.
module tb_blk_ctrl_responder;
    import blk_ctrl_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [2:0]        cmd_op;
    logic [2:0]        st_state;
    logic              st_busy, st_ack, st_err;
    logic [CW-1:0]     st_count;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;

    blk_ctrl_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .FLUSH_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .st_state  (st_state),
        .st_busy   (st_busy),
        .st_ack    (st_ack),
        .st_err    (st_err),
        .st_count  (st_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the edge; inputs changed here land on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input blk_cmd_e op);
        cmd_valid = 1'b1;
        cmd_op    = op;
    endtask

    task automatic no_cmd();
        cmd_valid = 1'b0;
        cmd_op    = CMD_NOP;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_state", st_state, 0);
        check("rst_count", st_count, 0);
        check("rst_ack", st_ack, 0);
        check("rst_err", st_err, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        rst = 1'b0;

        // START, then fill the buffer with out_ready low
        cmd(CMD_START); tick(); no_cmd();
        check("start_ack", st_ack, 1);
        check("start_state", st_state, 1);
        check("start_in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = 64'hA; tick();
        check("ack_pulse_once", st_ack, 0);
        check("push1_count", st_count, 1);
        in_data = 64'hB; tick();
        check("full_count", st_count, 2);
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        check("full_head", out_data, 64'hA);
        in_valid = 1'b0;

        // STALL retains contents, RESUME restores head order
        cmd(CMD_STALL); tick(); no_cmd();
        check("stall_state", st_state, 2);
        check("stall_out_valid", out_valid, 0);
        check("stall_in_ready", in_ready, 0);
        tick();
        check("stall_count_held", st_count, 2);
        cmd(CMD_RESUME); tick(); no_cmd();
        check("resume_ack", st_ack, 1);
        check("resume_state", st_state, 1);
        check("resume_head", out_data, 64'hA);
        out_ready = 1'b1; tick();
        check("pop1_data", out_data, 64'hB);
        check("pop1_count", st_count, 1);
        tick();
        check("pop2_count", st_count, 0);
        check("empty_out_valid", out_valid, 0);
        out_ready = 1'b0;

        // FLUSH with a push handshake in the same cycle
        in_valid = 1'b1; in_data = 64'hA; tick();
        in_data = 64'hB; tick();
        in_valid = 1'b0; out_ready = 1'b1; tick();
        check("preflush_head", out_data, 64'hB);
        out_ready = 1'b0;
        cmd(CMD_FLUSH); in_valid = 1'b1; in_data = 64'hC; tick();
        cmd(CMD_RESUME); in_valid = 1'b0;
        check("flush_state1", st_state, 3);
        check("flush_count", st_count, 0);
        check("flush_busy", st_busy, 1);
        check("flush_ack", st_ack, 1);
        tick(); no_cmd();
        check("flush_state2", st_state, 3);
        check("flush_cmd_err", st_err, 1);
        check("flush_cmd_no_ack", st_ack, 0);
        tick();
        check("flush_exit_state", st_state, 1);
        check("flush_exit_no_ack", st_ack, 0);
        check("flush_exit_count", st_count, 0);
        check("flush_discard", out_valid, 0);

        // STOP with one entry held by back-pressure
        in_valid = 1'b1; in_data = 64'hD; tick();
        in_valid = 1'b0;
        cmd(CMD_STOP); tick(); no_cmd();
        check("stop_ack", st_ack, 1);
        check("drain_state", st_state, 4);
        check("drain_in_ready", in_ready, 0);
        in_valid = 1'b1; in_data = 64'hE; tick(); tick();
        check("drain_hold_state", st_state, 4);
        check("drain_no_push", st_count, 1);
        check("drain_head", out_data, 64'hD);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        out_ready = 1'b0;
        check("drain_exit_state", st_state, 0);
        check("drain_exit_count", st_count, 0);

        // Illegal commands
        cmd(CMD_RESUME); tick();
        check("ill_resume_err", st_err, 1);
        check("ill_resume_ack", st_ack, 0);
        check("ill_resume_state", st_state, 0);
        cmd_op = 3'd7; tick(); no_cmd();
        check("ill_op7_err", st_err, 1);
        check("ill_op7_state", st_state, 0);
        tick();
        check("err_pulse_end", st_err, 0);
        cmd(CMD_START); tick();
        check("restart_ack", st_ack, 1);
        tick(); no_cmd();
        check("ill_start_err", st_err, 1);
        check("ill_start_ack", st_ack, 0);
        check("ill_start_state", st_state, 1);

        // Reset during DRAIN with two entries
        in_valid = 1'b1; in_data = 64'h1; tick();
        in_data = 64'h2; tick();
        in_valid = 1'b0;
        cmd(CMD_STOP); tick(); no_cmd();
        check("rd_state", st_state, 4);
        check("rd_count", st_count, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rd_rst_state", st_state, 0);
        check("rd_rst_count", st_count, 0);
        check("rd_rst_out_valid", out_valid, 0);
        cmd(CMD_START); tick(); no_cmd();
        check("rd_start_ack", st_ack, 1);
        check("rd_start_state", st_state, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
